ram_access_unit: RTL and testbench



---
 rtl/ram_pkg.sv | 32 +++
 rtl/ram_drain_ctr.sv | 24 ++
 rtl/ram_access_unit.sv | 151 +++++++++++++++
 tb/tb_ram_access_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the processor-side RAM access bridge.
package ram_pkg;
  localparam int RAM_ADDR_W = 24;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } ram_state_t;

  // Request fields latched at acceptance; store data lives in the write-word register.
  typedef struct packed {
    logic                we;
    logic                size;
    logic [RAM_ADDR_W:0] addr;
  } ram_req_t;

  // sel=0 replaces the low byte, sel=1 the high byte.
  function automatic logic [RAM_DATA_W-1:0] byte_merge(input logic [RAM_DATA_W-1:0] word,
                                                       input logic [7:0]            bval,
                                                       input logic                  sel);
    return sel ? {bval, word[7:0]} : {word[15:8], bval};
  endfunction

  function automatic logic [RAM_DATA_W-1:0] byte_extract(input logic [RAM_DATA_W-1:0] word,
                                                         input logic                  sel);
    return {8'h00, (sel ? word[15:8] : word[7:0])};
  endfunction
endpackage

// File: rtl/ram_drain_ctr.sv
// Saturating count of reads that timed out but whose data is still due from the RAM.
module ram_drain_ctr #(
  parameter int W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign nonzero = |cnt;
endmodule

// File: rtl/ram_access_unit.sv
// Byte/word load-store bridge into sdram_block: single-cycle push pulses,
// read-modify-write for byte stores, read timeout with stale-data draining.
module ram_access_unit
  import ram_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int DRAIN_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_size,
  input  logic [RAM_ADDR_W:0]   req_addr,
  input  logic [RAM_DATA_W-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [RAM_DATA_W-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [RAM_DATA_W-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  input  logic [RAM_DATA_W-1:0] ram_rd_data,
  input  logic                  ram_busy,
  input  logic                  ram_rd_ready,
  output logic                  ram_rd_ack
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  ram_state_t            state, next_state;
  ram_req_t              req_q;
  logic                  err_q;
  logic [RAM_DATA_W-1:0] rdata_q;
  logic [RAM_DATA_W-1:0] wr_word_q;
  logic [RAM_ADDR_W-1:0] addr_hold;
  logic [RAM_DATA_W-1:0] wdata_hold;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  ack_q;
  logic                  drain_nz;
  logic                  drain_pop;
  logic                  capture;
  logic                  tmo_hit;
  logic                  accept;
  logic                  misalign;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign misalign  = req_size && req_addr[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    ram_wr_en  = 1'b0;
    ram_rd_en  = 1'b0;
    capture    = 1'b0;
    tmo_hit    = 1'b0;
    // the FIFO flag needs a cycle to settle after any pop, hence ack_q
    drain_pop  = drain_nz && ram_rd_ready && !ack_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misalign)              next_state = RESP;
          else if (req_we && req_size) next_state = WR_ISSUE;
          else                       next_state = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (!ram_busy) begin
          ram_rd_en  = 1'b1;
          next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ram_rd_ready && !drain_nz && !ack_q) begin
          capture    = 1'b1;
          next_state = req_q.we ? WR_ISSUE : RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = RESP;
        end
      end
      WR_ISSUE: begin
        if (!ram_busy) begin
          ram_wr_en  = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ram_rd_ack = drain_pop || capture;
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = (state == RESP) ? rdata_q : '0;

  // Address/data show the new value throughout an issue state and are held afterwards.
  assign ram_addr    = (state == RD_ISSUE || state == WR_ISSUE) ? req_q.addr[RAM_ADDR_W:1] : addr_hold;
  assign ram_wr_data = (state == WR_ISSUE) ? wr_word_q : wdata_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      wr_word_q  <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      tmo_cnt    <= '0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= ram_rd_ack;
      if (accept) begin
        req_q     <= '{we: req_we, size: req_size, addr: req_addr};
        err_q     <= misalign;
        rdata_q   <= '0;
        wr_word_q <= req_wdata;
      end
      if (ram_rd_en || ram_wr_en) addr_hold <= req_q.addr[RAM_ADDR_W:1];
      if (ram_wr_en) wdata_hold <= wr_word_q;
      if (ram_rd_en)
        tmo_cnt <= '0;
      else if (state == RD_WAIT && tmo_cnt != TMO_LAST)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) err_q <= 1'b1;
      if (capture) begin
        if (req_q.we)
          wr_word_q <= byte_merge(ram_rd_data, wr_word_q[7:0], req_q.addr[0]);
        else if (req_q.size)
          rdata_q <= ram_rd_data;
        else
          rdata_q <= byte_extract(ram_rd_data, req_q.addr[0]);
      end
    end
  end

  ram_drain_ctr #(.W(DRAIN_W)) u_drain (
    .clk     (clk),
    .rst     (rst),
    .inc     (tmo_hit),
    .dec     (drain_pop),
    .nonzero (drain_nz)
  );
endmodule

// File: tb/tb_ram_access_unit.sv
// Directed bench for ram_access_unit: vector table plus busy, timeout/drain and reset sequences.
module tb_ram_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_size = 1'b0;
  logic [24:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [23:0] ram_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en;
  logic        ram_rd_en;
  logic [15:0] ram_rd_data = '0;
  logic        ram_busy = 1'b0;
  logic        ram_rd_ready = 1'b0;
  logic        ram_rd_ack;

  always #5 clk = ~clk;

  ram_access_unit #(.TIMEOUT(8), .DRAIN_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data), .ram_busy(ram_busy),
    .ram_rd_ready(ram_rd_ready), .ram_rd_ack(ram_rd_ack)
  );

  // RAM read-data FIFO model: pushes rd_word per read issue, pops on ack.
  logic [15:0] fifo[$];
  logic [15:0] rd_word = '0;
  bit          hold_rd = 1'b0;
  bit          flush_req = 1'b0;
  bit          en_s, ack_s, prev_ack;
  int          n_wr = 0, n_rd = 0, n_ack = 0, n_viol = 0;
  logic [23:0] wr_addr_s = '0, rd_addr_s = '0;
  logic [15:0] wr_data_s = '0;

  always @(negedge clk) begin
    en_s  = ram_rd_en;
    ack_s = ram_rd_ack;
    if (ram_wr_en) begin n_wr++; wr_addr_s = ram_addr; wr_data_s = ram_wr_data; end
    if (ram_rd_en) begin n_rd++; rd_addr_s = ram_addr; end
    if (ram_rd_ack) n_ack++;
    if ((ram_wr_en && ram_rd_en) || (ram_rd_ack && prev_ack)) n_viol++;
    prev_ack = ram_rd_ack;
  end

  always @(posedge clk) begin
    #1;
    if (flush_req) fifo.delete();
    else begin
      if (ack_s && fifo.size() > 0) void'(fifo.pop_front());
      if (en_s) fifo.push_back(rd_word);
    end
    ram_rd_ready = !hold_rd && (fifo.size() > 0);
    ram_rd_data  = (fifo.size() > 0) ? fifo[0] : 16'h0000;
  end

  int total = 0, bad = 0;
  int b_wr, b_rd, b_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic we, input logic size, input logic [24:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    b_wr = n_wr; b_rd = n_rd; b_ack = n_ack;
  endtask

  task automatic wait_resp(output int lat, output logic [15:0] rdata, output logic err);
    lat = -1; rdata = 'x; err = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (resp_valid) begin lat = k; rdata = resp_rdata; err = resp_err; break; end
    end
    #1;
  endtask

  typedef struct {
    logic        we;
    logic        size;
    logic [24:0] addr;
    logic [15:0] wdata;
    logic [15:0] ram_word;
    int          lat;
    logic        err;
    logic [15:0] rdata;
    int          nwr;
    int          nrd;
    logic [23:0] waddr;
    logic [15:0] wdat;
    logic [23:0] raddr;
  } vec_t;

  vec_t vt[10];

  initial begin
    int          lat, cnt;
    logic [15:0] rd;
    logic        er;

    vt[0] = '{1'b1, 1'b1, 25'h0000010, 16'hBEEF, 16'h0000, 2, 1'b0, 16'h0000, 1, 0, 24'h000008, 16'hBEEF, 24'h0};
    vt[1] = '{1'b1, 1'b0, 25'h0000003, 16'h005A, 16'h1234, 4, 1'b0, 16'h0000, 1, 1, 24'h000001, 16'h5A34, 24'h000001};
    vt[2] = '{1'b0, 1'b0, 25'h0000002, 16'h0000, 16'hA1B2, 3, 1'b0, 16'h00B2, 0, 1, 24'h0, 16'h0, 24'h000001};
    vt[3] = '{1'b0, 1'b0, 25'h0000003, 16'h0000, 16'hA1B2, 3, 1'b0, 16'h00A1, 0, 1, 24'h0, 16'h0, 24'h000001};
    vt[4] = '{1'b0, 1'b1, 25'h0000001, 16'h0000, 16'h7777, 1, 1'b1, 16'h0000, 0, 0, 24'h0, 16'h0, 24'h0};
    vt[5] = '{1'b0, 1'b1, 25'h0000004, 16'h0000, 16'hCAFE, 3, 1'b0, 16'hCAFE, 0, 1, 24'h0, 16'h0, 24'h000002};
    vt[6] = '{1'b1, 1'b0, 25'h0000004, 16'hFFC3, 16'h1234, 4, 1'b0, 16'h0000, 1, 1, 24'h000002, 16'h12C3, 24'h000002};
    vt[7] = '{1'b1, 1'b1, 25'h0000007, 16'h4321, 16'h0000, 1, 1'b1, 16'h0000, 0, 0, 24'h0, 16'h0, 24'h0};
    vt[8] = '{1'b0, 1'b1, 25'h1FFFFFE, 16'h0000, 16'h8001, 3, 1'b0, 16'h8001, 0, 1, 24'h0, 16'h0, 24'hFFFFFF};
    vt[9] = '{1'b1, 1'b0, 25'h1FFFFFF, 16'h0077, 16'hABCD, 4, 1'b0, 16'h0000, 1, 1, 24'hFFFFFF, 16'h77CD, 24'hFFFFFF};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst resp_rdata", {16'd0, resp_rdata}, 32'd0);
    chk("rst pulses", {29'd0, ram_wr_en, ram_rd_en, ram_rd_ack}, 32'd0);
    chk("rst ram_addr", {8'd0, ram_addr}, 32'd0);
    chk("rst ram_wr_data", {16'd0, ram_wr_data}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      rd_word = vt[i].ram_word;
      send(vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata);
      wait_resp(lat, rd, er);
      chk($sformatf("v%0d latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d err", i), {31'd0, er}, {31'd0, vt[i].err});
      chk($sformatf("v%0d rdata", i), {16'd0, rd}, {16'd0, vt[i].rdata});
      chk($sformatf("v%0d wr pulses", i), n_wr - b_wr, vt[i].nwr);
      chk($sformatf("v%0d rd pulses", i), n_rd - b_rd, vt[i].nrd);
      chk($sformatf("v%0d acks", i), n_ack - b_ack, vt[i].nrd);
      if (vt[i].nwr > 0) begin
        chk($sformatf("v%0d wr addr", i), {8'd0, wr_addr_s}, {8'd0, vt[i].waddr});
        chk($sformatf("v%0d wr data", i), {16'd0, wr_data_s}, {16'd0, vt[i].wdat});
      end
      if (vt[i].nrd > 0)
        chk($sformatf("v%0d rd addr", i), {8'd0, rd_addr_s}, {8'd0, vt[i].raddr});
    end

    // ram_busy held for 5 cycles in WR_ISSUE
    ram_busy = 1'b1;
    send(1'b1, 1'b1, 25'h0000020, 16'h1111);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_wr_en) cnt++;
    end
    chk("busy no pulse", cnt, 0);
    @(posedge clk); #1;
    ram_busy = 1'b0;
    @(negedge clk);
    chk("busy release pulse", {31'd0, ram_wr_en}, 32'd1);
    chk("busy addr", {8'd0, ram_addr}, 32'h10);
    chk("busy data", {16'd0, ram_wr_data}, 32'h1111);
    wait_resp(lat, rd, er);
    chk("busy resp latency", lat, 1);
    chk("busy wr count", n_wr - b_wr, 1);

    // timeout, then stale data drained ahead of the next load's data
    hold_rd = 1'b1;
    rd_word = 16'hDEAD;
    send(1'b0, 1'b1, 25'h0000010, 16'h0);
    wait_resp(lat, rd, er);
    chk("tmo latency", lat, 10);
    chk("tmo err", {31'd0, er}, 32'd1);
    chk("tmo rdata", {16'd0, rd}, 32'd0);
    chk("tmo acks", n_ack - b_ack, 0);
    rd_word = 16'hF00D;
    send(1'b0, 1'b1, 25'h0000010, 16'h0);
    repeat (3) @(negedge clk);
    hold_rd = 1'b0;
    wait_resp(lat, rd, er);
    chk("fresh err", {31'd0, er}, 32'd0);
    chk("fresh rdata", {16'd0, rd}, 32'hF00D);
    chk("drain+capture acks", n_ack - b_ack, 2);
    rd_word = 16'h1357;
    send(1'b0, 1'b1, 25'h0000012, 16'h0);
    wait_resp(lat, rd, er);
    chk("after drain rdata", {16'd0, rd}, 32'h1357);
    chk("after drain latency", lat, 3);
    chk("fifo empty", fifo.size(), 0);

    // reset mid-read aborts and clears the drain count
    hold_rd = 1'b1;
    rd_word = 16'h2468;
    send(1'b0, 1'b1, 25'h0000010, 16'h0);
    wait_resp(lat, rd, er);
    chk("tmo2 err", {31'd0, er}, 32'd1);
    send(1'b0, 1'b1, 25'h0000010, 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b1;
    hold_rd = 1'b0;
    b_ack = n_ack;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk("abort no resp", cnt, 0);
    chk("drain cleared no acks", n_ack - b_ack, 0);
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    rd_word = 16'h0ABC;
    send(1'b0, 1'b1, 25'h0000010, 16'h0);
    wait_resp(lat, rd, er);
    chk("post reset rdata", {16'd0, rd}, 32'h0ABC);
    chk("post reset err", {31'd0, er}, 32'd0);

    chk("protocol violations", n_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
